// File: rtl/alu_sequencer.sv
// Multi-cycle RV32I R/I-type ALU instruction sequencer: decode, execute, write-back.
// Optional ALU_SEQ_PERF_CNT_EN adds saturating retired/illegal counters.
module alu_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      alu_op,
    output logic            alu_src_imm,
    output logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_wdata,
    output logic            done,
    output logic            illegal
`ifdef ALU_SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] illegal_cnt
`endif
);

    localparam logic [1:0] StIdle      = 2'd0;
    localparam logic [1:0] StDecode    = 2'd1;
    localparam logic [1:0] StExecute   = 2'd2;
    localparam logic [1:0] StWriteback = 2'd3;

    localparam logic [6:0] OpcR = 7'b0110011;
    localparam logic [6:0] OpcI = 7'b0010011;
    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    localparam logic [4:0] OpAdd  = 5'b00000;
    localparam logic [4:0] OpSub  = 5'b00001;
    localparam logic [4:0] OpAnd  = 5'b00010;
    localparam logic [4:0] OpOr   = 5'b00011;
    localparam logic [4:0] OpXor  = 5'b00100;
    localparam logic [4:0] OpSll  = 5'b00101;
    localparam logic [4:0] OpSrl  = 5'b00110;
    localparam logic [4:0] OpSra  = 5'b00111;
    localparam logic [4:0] OpSlt  = 5'b01000;
    localparam logic [4:0] OpSltu = 5'b01001;

    logic [1:0]      state_q, state_d;
    logic [31:0]     instr_q;
    logic [4:0]      alu_op_q;
    logic            alu_src_imm_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] rd_wdata_q;
    logic            illegal_q;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      dec_op;
    logic            dec_src_imm;
    logic            dec_legal;
    logic [XLEN-1:0] dec_imm;

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];

    always_comb begin
        dec_op      = OpAdd;
        dec_src_imm = 1'b0;
        dec_legal   = 1'b0;
        dec_imm     = '0;
        if (opcode == OpcR) begin
            if (funct7 == F7Base) begin
                dec_legal = 1'b1;
                case (funct3)
                    3'b000:  dec_op = OpAdd;
                    3'b001:  dec_op = OpSll;
                    3'b010:  dec_op = OpSlt;
                    3'b011:  dec_op = OpSltu;
                    3'b100:  dec_op = OpXor;
                    3'b101:  dec_op = OpSrl;
                    3'b110:  dec_op = OpOr;
                    default: dec_op = OpAnd;
                endcase
            end else if (funct7 == F7Alt) begin
                if (funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = OpSub;
                end else if (funct3 == 3'b101) begin
                    dec_legal = 1'b1;
                    dec_op    = OpSra;
                end
            end
        end else if (opcode == OpcI) begin
            dec_src_imm = 1'b1;
            dec_imm     = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
            case (funct3)
                3'b000: begin dec_legal = 1'b1; dec_op = OpAdd;  end
                3'b010: begin dec_legal = 1'b1; dec_op = OpSlt;  end
                3'b011: begin dec_legal = 1'b1; dec_op = OpSltu; end
                3'b100: begin dec_legal = 1'b1; dec_op = OpXor;  end
                3'b110: begin dec_legal = 1'b1; dec_op = OpOr;   end
                3'b111: begin dec_legal = 1'b1; dec_op = OpAnd;  end
                3'b001: begin
                    dec_legal = (funct7 == F7Base);
                    dec_op    = OpSll;
                end
                default: begin
                    dec_legal = (funct7 == F7Base) || (funct7 == F7Alt);
                    dec_op    = (funct7 == F7Alt) ? OpSra : OpSrl;
                end
            endcase
        end
        // Rejected instructions leave the ALU controls at a neutral value.
        if (!dec_legal) begin
            dec_op      = OpAdd;
            dec_src_imm = 1'b0;
            dec_imm     = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:      if (instr_valid) state_d = StDecode;
            StDecode:    state_d = dec_legal ? StExecute : StIdle;
            StExecute:   state_d = StWriteback;
            default:     state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            instr_q       <= '0;
            alu_op_q      <= '0;
            alu_src_imm_q <= 1'b0;
            imm_q         <= '0;
            rd_wdata_q    <= '0;
            illegal_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= (state_q == StDecode) && !dec_legal;
            if (state_q == StIdle && instr_valid) begin
                instr_q <= instr;
            end
            if (state_q == StDecode) begin
                alu_op_q      <= dec_op;
                alu_src_imm_q <= dec_src_imm;
                imm_q         <= dec_imm;
            end
            if (state_q == StExecute) begin
                rd_wdata_q <= alu_result;
            end
        end
    end

    assign instr_ready = (state_q == StIdle) && !rst;
    assign rs1_addr    = instr_q[19:15];
    assign rs2_addr    = instr_q[24:20];
    assign rd_addr     = instr_q[11:7];
    assign alu_op      = alu_op_q;
    assign alu_src_imm = alu_src_imm_q;
    assign imm         = imm_q;
    assign rd_wdata    = rd_wdata_q;
    assign done        = (state_q == StWriteback);
    assign rd_we       = (state_q == StWriteback) && (instr_q[11:7] != 5'd0);
    assign illegal     = illegal_q;

`ifdef ALU_SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] retired_cnt_q;
    logic [CNT_W-1:0] illegal_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt_q <= '0;
            illegal_cnt_q <= '0;
        end else begin
            if (done && retired_cnt_q != {CNT_W{1'b1}}) begin
                retired_cnt_q <= retired_cnt_q + 1'b1;
            end
            if (illegal_q && illegal_cnt_q != {CNT_W{1'b1}}) begin
                illegal_cnt_q <= illegal_cnt_q + 1'b1;
            end
        end
    end

    assign retired_cnt = retired_cnt_q;
    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer; outputs sampled on the falling edge.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  rs1_addr, rs2_addr, alu_op, rd_addr;
    logic        alu_src_imm;
    logic [31:0] imm, alu_result, rd_wdata;
    logic        rd_we, done, illegal;
`ifdef ALU_SEQ_PERF_CNT_EN
    logic [15:0] retired_cnt, illegal_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.XLEN(32), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .imm         (imm),
        .alu_result  (alu_result),
        .rd_we       (rd_we),
        .rd_addr     (rd_addr),
        .rd_wdata    (rd_wdata),
        .done        (done),
        .illegal     (illegal)
`ifdef ALU_SEQ_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt),
        .illegal_cnt (illegal_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the DUT idle; leaves it idle at a falling edge.
    task automatic run_instr(input string name, input logic [31:0] word, input logic [31:0] res,
                             input logic is_illegal, input logic [4:0] e_op, input logic e_src,
                             input logic [31:0] e_imm, input logic [4:0] e_rs1,
                             input logic [4:0] e_rs2, input logic [4:0] e_rd);
        check_eq({name, ".ready_pre"}, {31'd0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        instr       = word;
        @(negedge clk);  // N+1
        instr_valid = 1'b0;
        instr       = 32'hDEAD_BEEF;
        check_eq({name, ".ready_n1"}, {31'd0, instr_ready}, 32'd0);
        if (!is_illegal) begin
            check_eq({name, ".rs1"}, {27'd0, rs1_addr}, {27'd0, e_rs1});
            check_eq({name, ".rs2"}, {27'd0, rs2_addr}, {27'd0, e_rs2});
        end
        @(negedge clk);  // N+2
        if (is_illegal) begin
            check_eq({name, ".illegal_n2"}, {31'd0, illegal}, 32'd1);
            check_eq({name, ".ready_n2"}, {31'd0, instr_ready}, 32'd1);
            check_eq({name, ".done_n2"}, {31'd0, done}, 32'd0);
            check_eq({name, ".we_n2"}, {31'd0, rd_we}, 32'd0);
            @(negedge clk);
            check_eq({name, ".illegal_n3"}, {31'd0, illegal}, 32'd0);
            check_eq({name, ".done_n3"}, {31'd0, done}, 32'd0);
            check_eq({name, ".we_n3"}, {31'd0, rd_we}, 32'd0);
        end else begin
            check_eq({name, ".illegal_n2"}, {31'd0, illegal}, 32'd0);
            check_eq({name, ".op"}, {27'd0, alu_op}, {27'd0, e_op});
            check_eq({name, ".src_imm"}, {31'd0, alu_src_imm}, {31'd0, e_src});
            check_eq({name, ".imm"}, imm, e_imm);
            check_eq({name, ".done_n2"}, {31'd0, done}, 32'd0);
            alu_result = res;
            @(negedge clk);  // N+3
            alu_result = 32'h0BAD_F00D;
            check_eq({name, ".we_n3"}, {31'd0, rd_we}, {31'd0, e_rd != 5'd0});
            check_eq({name, ".done_n3"}, {31'd0, done}, 32'd1);
            check_eq({name, ".rd_addr"}, {27'd0, rd_addr}, {27'd0, e_rd});
            check_eq({name, ".wdata"}, rd_wdata, res);
            check_eq({name, ".ready_n3"}, {31'd0, instr_ready}, 32'd0);
            @(negedge clk);  // N+4
            check_eq({name, ".ready_n4"}, {31'd0, instr_ready}, 32'd1);
            check_eq({name, ".done_n4"}, {31'd0, done}, 32'd0);
            check_eq({name, ".we_n4"}, {31'd0, rd_we}, 32'd0);
        end
    endtask

    initial begin
        int n_done;
        int n_we;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        alu_result  = '0;
        repeat (2) @(negedge clk);
        check_eq("rst.ready_in_rst", {31'd0, instr_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rst.ready", {31'd0, instr_ready}, 32'd1);
        check_eq("rst.flags", {29'd0, rd_we, done, illegal}, 32'd0);
        check_eq("rst.wdata", rd_wdata, 32'd0);
        check_eq("rst.imm", imm, 32'd0);
        check_eq("rst.addrs", {17'd0, rs1_addr, rs2_addr, rd_addr}, 32'd0);
        check_eq("rst.op", {26'd0, alu_op, alu_src_imm}, 32'd0);
        @(negedge clk);

        //        name    word          result        ill   op        src   imm           rs1 rs2 rd
        run_instr("add",  32'h002081B3, 32'h00000007, 1'b0, 5'b00000, 1'b0, 32'h00000000, 1,  2,  3);
        run_instr("sub",  32'h407302B3, 32'hFFFFFFFF, 1'b0, 5'b00001, 1'b0, 32'h00000000, 6,  7,  5);
        run_instr("addi", 32'hFFF00093, 32'hFFFFFFFF, 1'b0, 5'b00000, 1'b1, 32'hFFFFFFFF, 0,  31, 1);
        run_instr("srai", 32'h4041D113, 32'h12345678, 1'b0, 5'b00111, 1'b1, 32'h00000404, 3,  4,  2);
        run_instr("add0", 32'h00208033, 32'h00000003, 1'b0, 5'b00000, 1'b0, 32'h00000000, 1,  2,  0);
        run_instr("ill0", 32'h00000000, 32'h0,        1'b1, 5'b00000, 1'b0, 32'h0,        0,  0,  0);
        run_instr("ill7", 32'h40007033, 32'h0,        1'b1, 5'b00000, 1'b0, 32'h0,        0,  0,  0);
        run_instr("slli_bad", 32'h40109093, 32'h0,    1'b1, 5'b00000, 1'b0, 32'h0,        0,  0,  0);

        // Back-to-back with instr_valid held: retire at N+3 and N+7.
        instr_valid = 1'b1;
        instr       = 32'h407302B3;
        alu_result  = 32'h0000_00AA;
        n_done      = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 8) instr_valid = 1'b0;
            if (done) n_done++;
            if (i == 3 || i == 7) check_eq($sformatf("b2b.done_%0d", i), {31'd0, done}, 32'd1);
            if (i == 4) check_eq("b2b.ready_4", {31'd0, instr_ready}, 32'd1);
        end
        check_eq("b2b.done_count", n_done, 32'd2);
        @(negedge clk);

        // Reset during EXECUTE discards the instruction.
        instr_valid = 1'b1;
        instr       = 32'h002081B3;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        alu_result = 32'h0000_0055;
        rst        = 1'b1;
        @(negedge clk);
        check_eq("rstx.flags", {29'd0, rd_we, done, illegal}, 32'd0);
        check_eq("rstx.ready_in_rst", {31'd0, instr_ready}, 32'd0);
        check_eq("rstx.wdata", rd_wdata, 32'd0);
        check_eq("rstx.addrs", {17'd0, rs1_addr, rs2_addr, rd_addr}, 32'd0);
        check_eq("rstx.op", {26'd0, alu_op, alu_src_imm}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rstx.ready", {31'd0, instr_ready}, 32'd1);
        n_we   = 0;
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rd_we) n_we++;
            if (done) n_done++;
        end
        check_eq("rstx.no_we", n_we, 32'd0);
        check_eq("rstx.no_done", n_done, 32'd0);

        // Sequencer still works after the aborted instruction.
        run_instr("post", 32'h002081B3, 32'h00000009, 1'b0, 5'b00000, 1'b0, 32'h0, 1, 2, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle instruction sequencer for the RISC-V ALU datapath. Accepts one 32-bit RV32I R-type or I-type ALU instruction per handshake, and decodes funct3/funct7 into the 5-bit ALU op, including the ADD/SUB and SRL/SRA distinction. It then sequences the register-file read, the ALU execute step and the register write-back. It sits between the instruction source and the register file/ALU pair.

## Interface
- XLEN, 32, datapath width; the immediate is sign-extended to XLEN
- CNT_W, 16, performance counter width (used only with the macro)

- clk  in  1  rising-edge clock
- rst  in  1  reset: synchronous, active-high
- instr_valid  in  1  instruction offered
- instr  in  32  instruction word
- instr_ready  out  1  sequencer idle; can accept
- rs1_addr, rs2_addr  out  5 each  register-file read addresses
- alu_op  out  5  ALU operation
- alu_src_imm  out  1  1 selects `imm` as ALU operand B
- imm  out  XLEN  sign-extended I-type immediate
- alu_result  in  XLEN  combinational ALU output
- rd_we  out  1  register write enable, one-cycle pulse
- rd_addr  out  5  write address
- rd_wdata  out  XLEN  write data
- done  out  1  instruction retired, one-cycle pulse
- illegal  out  1  instruction rejected, one-cycle pulse

## Operation
- States:
  - IDLE: accept when `instr_valid && instr_ready`, latch `instr_q`, go to DECODE.
  - DECODE: go to EXECUTE, or to IDLE for an illegal instruction.
  - EXECUTE: capture `alu_result` into `rd_wdata`, go to WRITEBACK.
  - WRITEBACK: go to IDLE.
- `instr_ready` = (state == IDLE) and `rst` low. `instr` is ignored outside IDLE.
- `rs1_addr` = `instr_q[19:15]`, `rs2_addr` = `instr_q[24:20]` and `rd_addr` = `instr_q[11:7]` are held from DECODE through WRITEBACK.
- `alu_op` encoding:
  - ADD=00000, SUB=00001, AND=00010, OR=00011, XOR=00100
  - SLL=00101, SRL=00110, SRA=00111, SLT=01000, SLTU=01001
- R-type (opcode 0110011):
  - funct7 0000000 is valid for all funct3.
  - funct7 0100000 is valid only with funct3 000 (SUB) and 101 (SRA).
  - `alu_src_imm` = 0.
- I-type (opcode 0010011):
  - `alu_src_imm` = 1; `imm` = sign-extended `instr_q[31:20]`.
  - SLLI requires funct7 0000000.
  - SRLI/SRAI require funct7 0000000/0100000.
  - For shifts, `imm` carries shamt in bits [4:0].
- Any other opcode or funct combination is illegal: pulse `illegal`, no write-back, no `done`.
- `rd_addr` == 0: `done` still pulses, `rd_we` stays 0.
- `alu_op`, `imm` and `alu_src_imm` are registered on DECODE exit and hold until the next DECODE exit.

## Timing
- Reset value of every output is 0, except `instr_ready` = 1 in the first cycle after `rst` deasserts.
- `rst` asserted in any state: IDLE on the next edge, with `rd_we`/`done`/`illegal` = 0. An in-flight instruction is discarded and never written.
- Cycle N: handshake edge.
- N+1: DECODE.
- N+2: EXECUTE, with `alu_op`/`imm` stable; `alu_result` is sampled at the end of N+2.
- N+3: `rd_we`/`done` high.
- N+4: `instr_ready` = 1.
- Throughput: one instruction per 4 cycles.
- Illegal instruction: `illegal` high in N+2 and `instr_ready` = 1 in N+2.
- `instr_valid` held high continuously: the next instruction is accepted in the first cycle `instr_ready` is 1.

## Configuration
- `ALU_SEQ_PERF_CNT_EN` defined: adds outputs `retired_cnt` [CNT_W] and `illegal_cnt` [CNT_W].
  - `retired_cnt` increments on each `done`; `illegal_cnt` increments on each `illegal`.
  - Both saturate at all-ones and clear on `rst`.
- Undefined: neither port nor the counter logic exists; all other behaviour is identical.

## Test plan
- ADD x3,x1,x2 (0x002081B3) accepted at N, `alu_result`=0x00000007 in N+2:
  - N+2: `alu_op`=00000, `alu_src_imm`=0.
  - N+3: `rd_we`=1, `rd_addr`=3, `rd_wdata`=0x00000007, `done`=1.
- SUB x5,x6,x7 (0x407302B3):
  - `rs1_addr`=6, `rs2_addr`=7, `alu_op`=00001.
  - N+3: `rd_addr`=5.
- ADDI x1,x0,-1 (0xFFF00093):
  - `imm`=0xFFFFFFFF, `alu_src_imm`=1, `alu_op`=00000, `rd_addr`=1.
- Illegal word 0x00000000, and R-type funct7 0100000 with funct3 111:
  - `illegal`=1 in N+2, `instr_ready`=1 in N+2, no `rd_we`, no `done`.
- ADD x0,x1,x2 (0x00208033): `done`=1 at N+3 with `rd_we`=0.
- `rst` pulsed during EXECUTE:
  - Next cycle all outputs 0.
  - No `rd_we` ever issued for that instruction.
  - `instr_ready`=1 after `rst` falls.
